// File: rtl/vc_5_32_decode_scoreboard_if.sv
// Allocation/release/lookup bundle for the 32-entry decode scoreboard.
interface vc_5_32_decode_scoreboard_if #(
  parameter int unsigned p_nbits     = 32,
  parameter int unsigned p_idx_nbits = 5
);
  localparam int unsigned c_cnt_nbits = $clog2(p_nbits + 1);

  logic                   set_val;
  logic                   set_rdy;
  logic [p_idx_nbits-1:0] set_idx;
  logic                   clr_val;
  logic [p_idx_nbits-1:0] clr_idx;
  logic [p_idx_nbits-1:0] chk_idx;
  logic                   chk_hit;
  logic [p_nbits-1:0]     mask;
  logic [p_nbits-1:0]     set_onehot;
  logic [c_cnt_nbits-1:0] count;
  logic                   full;
  logic                   empty;
  logic                   err;

  modport master (
    output set_val, set_idx, clr_val, clr_idx, chk_idx,
    input  set_rdy, chk_hit, mask, set_onehot, count, full, empty, err
  );

  modport slave (
    input  set_val, set_idx, clr_val, clr_idx, chk_idx,
    output set_rdy, chk_hit, mask, set_onehot, count, full, empty, err
  );
endinterface

// File: rtl/vc_5_32_decode_scoreboard.sv
// Slot scoreboard: decodes set/clear indices into one-hot updates of a
// registered valid-bit vector, with occupancy count and a sticky misuse flag.
module vc_5_32_decode_scoreboard #(
  parameter int unsigned p_nbits     = 32,
  parameter int unsigned p_idx_nbits = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  vc_5_32_decode_scoreboard_if.slave    sb
);
  localparam int unsigned c_cnt_nbits = $clog2(p_nbits + 1);

  logic [p_nbits-1:0]     mask_q, mask_d;
  logic [p_nbits-1:0]     onehot_q, onehot_d;
  logic [c_cnt_nbits-1:0] count_q, count_d;
  logic                   err_q, err_d;

  logic [p_nbits-1:0]     set_dec, clr_dec;
  logic                   same_idx, set_rdy, set_go, clr_go;
  logic                   set_new, clr_old, bad_clr, bad_set;

  // Decode, handshake and next-state; a set to a slot released this cycle is allowed.
  always_comb begin
    set_dec  = p_nbits'(1) << sb.set_idx;
    clr_dec  = p_nbits'(1) << sb.clr_idx;
    same_idx = (sb.set_idx == sb.clr_idx);
    set_rdy  = ~mask_q[sb.set_idx] | (sb.clr_val & same_idx);
    set_go   = sb.set_val & set_rdy;
    clr_go   = sb.clr_val;

    set_new  = set_go & ~mask_q[sb.set_idx];
    clr_old  = clr_go & mask_q[sb.clr_idx] & ~(set_go & same_idx);
    bad_clr  = sb.clr_val & ~mask_q[sb.clr_idx] & ~(set_go & same_idx);
    bad_set  = sb.set_val & ~set_rdy;

    mask_d   = (mask_q & ~(clr_go ? clr_dec : '0)) | (set_go ? set_dec : '0);
    count_d  = count_q + c_cnt_nbits'(set_new) - c_cnt_nbits'(clr_old);
    onehot_d = set_go ? set_dec : '0;
    err_d    = err_q | bad_clr | bad_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      onehot_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      onehot_q <= onehot_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Flags come from the count register so they never see a combinational input path.
  always_comb begin
    sb.set_rdy    = set_rdy;
    sb.chk_hit    = mask_q[sb.chk_idx];
    sb.mask       = mask_q;
    sb.set_onehot = onehot_q;
    sb.count      = count_q;
    sb.full       = (count_q == c_cnt_nbits'(p_nbits));
    sb.empty      = (count_q == '0);
    sb.err        = err_q;
  end
endmodule

// File: tb/tb_vc_5_32_decode_scoreboard.sv
// Directed bench for the decode scoreboard: slot-array model checked every cycle
// plus literal expectations along the planned scenarios.
module tb_vc_5_32_decode_scoreboard;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vc_5_32_decode_scoreboard_if #(.p_nbits(32), .p_idx_nbits(5)) sb ();

  vc_5_32_decode_scoreboard #(.p_nbits(32), .p_idx_nbits(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model state: one flag per slot, index of last accepted set (-1 = none), sticky error.
  bit slot [32];
  int m_last;
  bit m_err;
  bit m_rdy, m_go;
  int m_si, m_ci;

  function automatic logic [31:0] exp_mask();
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 32; i++) if (slot[i]) v = v | (32'h1 << i);
    return v;
  endfunction

  function automatic int exp_count();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(slot[i]);
    return n;
  endfunction

  function automatic logic exp_rdy();
    return !slot[int'(sb.set_idx)] || (sb.clr_val && sb.clr_idx == sb.set_idx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) slot[i] = 1'b0;
      m_last = -1;
      m_err  = 1'b0;
    end else begin
      m_si  = int'(sb.set_idx);
      m_ci  = int'(sb.clr_idx);
      m_rdy = !slot[m_si] || (sb.clr_val && m_ci == m_si);
      m_go  = sb.set_val && m_rdy;
      if (sb.clr_val && !slot[m_ci] && !(m_go && m_si == m_ci)) m_err = 1'b1;
      if (sb.set_val && !m_rdy) m_err = 1'b1;
      if (sb.clr_val) slot[m_ci] = 1'b0;
      if (m_go) slot[m_si] = 1'b1;
      m_last = m_go ? m_si : -1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mask",    sb.mask, exp_mask());
    check("count",   32'(sb.count), exp_count());
    check("full",    32'(sb.full),  32'(exp_count() == 32));
    check("empty",   32'(sb.empty), 32'(exp_count() == 0));
    check("err",     32'(sb.err),   32'(m_err));
    check("onehot",  sb.set_onehot, (m_last < 0) ? 32'h0 : (32'h1 << m_last));
    check("chk_hit", 32'(sb.chk_hit), 32'(slot[int'(sb.chk_idx)]));
    check("set_rdy", 32'(sb.set_rdy), 32'(exp_rdy()));
  end

  // Drive one cycle of requests; optionally pin set_rdy to a literal before the edge.
  task automatic cyc(input bit sv, input int si, input bit cv, input int ci,
                     input int chk, input int rdy_lit);
    sb.set_val = sv;
    sb.set_idx = 5'(si);
    sb.clr_val = cv;
    sb.clr_idx = 5'(ci);
    sb.chk_idx = 5'(chk);
    #1;
    if (rdy_lit >= 0) check("set_rdy_lit", 32'(sb.set_rdy), 32'(rdy_lit));
    @(posedge clk);
    #1;
    sb.set_val = 1'b0;
    sb.clr_val = 1'b0;
  endtask

  initial begin
    sb.set_val = 1'b0;
    sb.set_idx = 5'd0;
    sb.clr_val = 1'b0;
    sb.clr_idx = 5'd0;
    sb.chk_idx = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("init_empty", 32'(sb.empty), 32'd1);

    // Single set of slot 5, then its pulse drops and the lookup hits.
    cyc(1'b1, 5, 1'b0, 0, 5, 1);
    check("s5_mask",   sb.mask,       32'h0000_0020);
    check("s5_onehot", sb.set_onehot, 32'h0000_0020);
    check("s5_count",  32'(sb.count), 32'd1);
    cyc(1'b0, 0, 1'b0, 0, 5, -1);
    check("s5_onehot_drop", sb.set_onehot, 32'h0);
    check("s5_chk_hit",     32'(sb.chk_hit), 32'd1);
    cyc(1'b0, 0, 1'b1, 5, 0, -1);
    check("c5_count", 32'(sb.count), 32'd0);

    // Fill every slot back to back, then attempt a double allocation.
    for (int i = 0; i < 32; i++) cyc(1'b1, i, 1'b0, 0, i, 1);
    check("fill_count", 32'(sb.count), 32'd32);
    check("fill_full",  32'(sb.full),  32'd1);
    check("fill_mask",  sb.mask,       32'hFFFF_FFFF);
    check("fill_err",   32'(sb.err),   32'd0);
    cyc(1'b1, 7, 1'b0, 0, 7, 0);
    check("dbl_err",   32'(sb.err),   32'd1);
    check("dbl_count", 32'(sb.count), 32'd32);

    // Same-cycle release and reuse while full.
    cyc(1'b1, 7, 1'b1, 7, 7, 1);
    check("reuse_mask",   sb.mask,       32'hFFFF_FFFF);
    check("reuse_count",  32'(sb.count), 32'd32);
    check("reuse_err",    32'(sb.err),   32'd1);
    check("reuse_onehot", sb.set_onehot, 32'h0000_0080);

    // Drain to slot 0 only, then set 31 while clearing 0.
    for (int i = 31; i >= 1; i--) cyc(1'b0, 0, 1'b1, i, 0, -1);
    check("drain_mask", sb.mask, 32'h0000_0001);
    cyc(1'b1, 31, 1'b1, 0, 31, 1);
    check("swap_mask",   sb.mask,       32'h8000_0000);
    check("swap_count",  32'(sb.count), 32'd1);
    check("swap_onehot", sb.set_onehot, 32'h8000_0000);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mask",   sb.mask,         32'h0);
    check("arst_count",  32'(sb.count),   32'd0);
    check("arst_empty",  32'(sb.empty),   32'd1);
    check("arst_full",   32'(sb.full),    32'd0);
    check("arst_err",    32'(sb.err),     32'd0);
    check("arst_hit",    32'(sb.chk_hit), 32'd0);
    check("arst_onehot", sb.set_onehot,   32'h0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Illegal clear of an empty slot raises a sticky error.
    cyc(1'b0, 0, 1'b1, 3, 3, -1);
    check("ill_mask",  sb.mask,       32'h0);
    check("ill_count", 32'(sb.count), 32'd0);
    check("ill_err",   32'(sb.err),   32'd1);
    cyc(1'b1, 2, 1'b0, 0, 2, 1);
    cyc(1'b0, 0, 1'b1, 2, 2, -1);
    check("sticky_err",   32'(sb.err),   32'd1);
    check("sticky_count", 32'(sb.count), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_err_clr", 32'(sb.err), 32'd0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
